// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads 16-bit words from a synchronous ROM,
// gathers 1- or 2-word instructions and hands pre-split fields to decode over valid/ready.
module ins_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [1:0]        ins_byte,
  output logic [1:0]        ins_mode,
  output logic [1:0]        ins_ot,
  output logic [2:0]        ins_op1,
  output logic [2:0]        ins_op2,
  output logic [3:0]        ins_opcode,
  output logic [15:0]       ins_ext,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_illegal
);

  localparam int unsigned WORD_W  = 16;
  localparam logic [1:0]  LEN_TWO = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    CAP0   = 3'd2,
    ISSUE1 = 3'd3,
    CAP1   = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;
  logic              take_pc;
  logic              cap_first;
  logic              cap_ext;
  logic [1:0]        len_code;

  // The ROM is addressed straight from the PC register.
  assign rom_addr = pc;
  assign len_code = rom_data[WORD_W-1:WORD_W-2];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes; redirect overrides everything and kills in-flight work.
  always_comb begin
    next_state = state;
    pc_inc     = 1'b0;
    take_pc    = 1'b0;
    cap_first  = 1'b0;
    cap_ext    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          next_state = ISSUE0;
        end
      end
      ISSUE0: begin
        pc_inc     = 1'b1;
        take_pc    = 1'b1;
        next_state = CAP0;
      end
      CAP0: begin
        cap_first  = 1'b1;
        next_state = (len_code == LEN_TWO) ? ISSUE1 : HOLD;
      end
      ISSUE1: begin
        pc_inc     = 1'b1;
        next_state = CAP1;
      end
      CAP1: begin
        cap_ext    = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        if (ins_ready) begin
          next_state = en ? ISSUE0 : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (redirect) begin
      next_state = en ? ISSUE0 : IDLE;
      pc_inc     = 1'b0;
      take_pc    = 1'b0;
      cap_first  = 1'b0;
      cap_ext    = 1'b0;
    end
  end

  // PC, handshake flag and instruction field registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ins_valid   <= 1'b0;
      ins_byte    <= '0;
      ins_mode    <= '0;
      ins_ot      <= '0;
      ins_op1     <= '0;
      ins_op2     <= '0;
      ins_opcode  <= '0;
      ins_ext     <= '0;
      ins_pc      <= '0;
      ins_illegal <= 1'b0;
    end else begin
      if (redirect) begin
        pc <= redirect_addr;
      end else if (pc_inc) begin
        pc <= pc + ADDR_W'(1);
      end
      ins_valid <= (next_state == HOLD);
      if (take_pc) begin
        ins_pc <= pc;
      end
      if (cap_first) begin
        ins_byte    <= len_code;
        ins_mode    <= rom_data[13:12];
        ins_ot      <= rom_data[11:10];
        ins_op1     <= rom_data[9:7];
        ins_op2     <= rom_data[6:4];
        ins_opcode  <= rom_data[3:0];
        ins_ext     <= '0;
        ins_illegal <= (len_code == 2'b00) || (len_code == 2'b11);
      end
      if (cap_ext) begin
        ins_ext <= rom_data;
      end
    end
  end

endmodule
